ps2_paddle_cmd_decoder: RTL and testbench

//  Converts PS/2 set-2 scan-code bytes into rate-limited one-hot paddle_movement pulses for the paddle movement stage.

---
 rtl/ps2_paddle_cmd_decoder.sv | 139 +++++++++++++
 tb/tb_ps2_paddle_cmd_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_paddle_cmd_decoder.sv
// PS/2 set-2 scan-code decoder producing rate-limited one-hot paddle move pulses.
// Optional pause key (Space toggles stand) enabled by defining PADDLE_PAUSE_KEY_EN.
module ps2_paddle_cmd_decoder #(
    parameter int unsigned STEP_TICKS = 2_500_000,
    parameter int unsigned CNT_W      = 22
) (
    input  logic       clk,
    input  logic       reset_to_start_n,
    input  logic [7:0] ps2_data_out,
    input  logic       ps2_data_valid,
    output logic [3:0] paddle_movement,
    output logic [3:0] keys_held,
    output logic       stand
);

    localparam logic [CNT_W-1:0] TickLast = CNT_W'(STEP_TICKS - 1);

    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeR     = 8'h2D;
    localparam logic [7:0] CodeF     = 8'h2B;
    localparam logic [7:0] CodeY     = 8'h35;
    localparam logic [7:0] CodeH     = 8'h33;

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;
    typedef enum logic {TurnLeft, TurnRight} turn_e;

    state_e           state_q;
    turn_e            turn_q;
    logic [CNT_W-1:0] timer_q;

    logic       tick;
    logic [3:0] key_mask;
    logic       left_req, right_req, pick_left;
    logic [3:0] left_code, right_code;

    always_comb begin
        key_mask = 4'b0000;
        case (ps2_data_out)
            CodeR:   key_mask = 4'b1000;
            CodeF:   key_mask = 4'b0100;
            CodeY:   key_mask = 4'b0010;
            CodeH:   key_mask = 4'b0001;
            default: key_mask = 4'b0000;
        endcase
    end

    assign tick       = (timer_q == TickLast);
    assign left_req   = keys_held[3] ^ keys_held[2];
    assign right_req  = keys_held[1] ^ keys_held[0];
    assign left_code  = keys_held[3] ? 4'b1000 : 4'b0100;
    assign right_code = keys_held[1] ? 4'b0010 : 4'b0001;
    // Left wins when it alone requests, or when both request and it is left's turn.
    assign pick_left  = left_req && (!right_req || (turn_q == TurnLeft));

    always_ff @(posedge clk or negedge reset_to_start_n) begin
        if (!reset_to_start_n) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_to_start_n) begin
        if (!reset_to_start_n) begin
            state_q         <= StIdle;
            turn_q          <= TurnLeft;
            keys_held       <= 4'b0000;
            paddle_movement <= 4'b0000;
        end else begin
            paddle_movement <= 4'b0000;
            if (tick && !stand && (left_req || right_req)) begin
                if (pick_left) begin
                    paddle_movement <= left_code;
                    turn_q          <= TurnRight;
                end else begin
                    paddle_movement <= right_code;
                    turn_q          <= TurnLeft;
                end
            end

            if (ps2_data_valid) begin
                unique case (state_q)
                    StIdle: begin
                        if (ps2_data_out == CodeBrk) begin
                            state_q <= StBrk;
                        end else if (ps2_data_out == CodeExt) begin
                            state_q <= StExt;
                        end else begin
                            keys_held <= keys_held | key_mask;
                        end
                    end
                    StBrk: begin
                        keys_held <= keys_held & ~key_mask;
                        state_q   <= StIdle;
                    end
                    StExt: begin
                        state_q <= (ps2_data_out == CodeBrk) ? StExtBrk : StIdle;
                    end
                    StExtBrk: begin
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef PADDLE_PAUSE_KEY_EN
    localparam logic [7:0] CodeSpace = 8'h29;

    logic stand_q;
    logic space_held_q;

    // space_held suppresses typematic repeats so only a fresh press toggles the pause.
    always_ff @(posedge clk or negedge reset_to_start_n) begin
        if (!reset_to_start_n) begin
            stand_q      <= 1'b0;
            space_held_q <= 1'b0;
        end else if (ps2_data_valid && (ps2_data_out == CodeSpace)) begin
            if (state_q == StIdle) begin
                if (!space_held_q) begin
                    stand_q <= ~stand_q;
                end
                space_held_q <= 1'b1;
            end else if (state_q == StBrk) begin
                space_held_q <= 1'b0;
            end
        end
    end

    assign stand = stand_q;
`else
    assign stand = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_paddle_cmd_decoder.sv
// Self-checking bench: directed scan-code scenarios plus random byte streams, checked every
// cycle against a protocol-level model of held keys, tick spacing and fair turn-taking.
module tb_ps2_paddle_cmd_decoder;

    localparam int unsigned Step = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic [3:0] paddle_movement;
    logic [3:0] keys_held;
    logic       stand;

    always #5 clk = ~clk;

    ps2_paddle_cmd_decoder #(
        .STEP_TICKS(Step),
        .CNT_W     (2)
    ) dut (
        .clk             (clk),
        .reset_to_start_n(rst_n),
        .ps2_data_out    (data),
        .ps2_data_valid  (valid),
        .paddle_movement (paddle_movement),
        .keys_held       (keys_held),
        .stand           (stand)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: which keys are down, pending prefixes seen, cycle phase and whose turn.
    logic [3:0] m_held;
    logic [3:0] m_pm;
    logic       m_stand;
    logic       m_space;
    bit         m_f0, m_e0, m_right_turn;
    int         m_cnt;
    logic [3:0] pulses[$];

    function automatic int key_idx(input logic [7:0] b);
        case (b)
            8'h2D:   return 3;
            8'h2B:   return 2;
            8'h35:   return 1;
            8'h33:   return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_held = 4'b0; m_pm = 4'b0; m_stand = 1'b0; m_space = 1'b0;
        m_f0 = 0; m_e0 = 0; m_right_turn = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        k = key_idx(b);
        if (m_e0) begin
            if (m_f0) begin
                m_e0 = 0; m_f0 = 0;
            end else if (b == 8'hF0) m_f0 = 1;
            else m_e0 = 0;
        end else if (m_f0) begin
            if (k >= 0) m_held[k] = 1'b0;
`ifdef PADDLE_PAUSE_KEY_EN
            if (b == 8'h29) m_space = 1'b0;
`endif
            m_f0 = 0;
        end else if (b == 8'hF0) m_f0 = 1;
        else if (b == 8'hE0) m_e0 = 1;
        else begin
            if (k >= 0) m_held[k] = 1'b1;
`ifdef PADDLE_PAUSE_KEY_EN
            if (b == 8'h29) begin
                if (!m_space) m_stand = !m_stand;
                m_space = 1'b1;
            end
`endif
        end
    endtask

    // One clock edge of the model: pulse decided from keys as they were before this edge's byte.
    task automatic model_clock();
        logic [3:0] nxt;
        bit lr, rr;
        nxt = 4'b0;
        lr = (m_held[3] != m_held[2]);
        rr = (m_held[1] != m_held[0]);
        if (m_cnt == Step - 1 && !m_stand) begin
            if (lr && (!rr || !m_right_turn)) begin
                nxt = m_held[3] ? 4'd8 : 4'd4;
                m_right_turn = 1;
            end else if (rr) begin
                nxt = m_held[1] ? 4'd2 : 4'd1;
                m_right_turn = 0;
            end
        end
        m_cnt = (m_cnt + 1) % Step;
        if (valid) model_byte(data);
        m_pm = nxt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle: model follows the posedge, outputs compared at the next negedge.
    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check("paddle_movement", 32'(paddle_movement), 32'(m_pm));
        check("keys_held", 32'(keys_held), 32'(m_held));
        check("stand", 32'(stand), 32'(m_stand));
        check("onehot", 32'($countones(paddle_movement) <= 1), 32'd1);
        if (paddle_movement != 4'b0) pulses.push_back(paddle_movement);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_pm", 32'(paddle_movement), 32'd0);
        check("reset_held", 32'(keys_held), 32'd0);
        check("reset_stand", 32'(stand), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    logic [7:0] byte_tab[10] = '{8'h2D, 8'h2B, 8'h35, 8'h33, 8'hF0, 8'hF0, 8'hE0, 8'h12,
                                 8'h29, 8'h1C};

    initial begin
        @(negedge clk);

        // Single held key: two pulses in any 8-cycle window, all L-up.
        do_reset();
        send(8'h2D);
        check("held_after_make", 32'(keys_held), 32'h8);
        pulses.delete();
        idle(8);
        check("r_pulse_count", 32'(pulses.size()), 32'd2);
        foreach (pulses[i]) check("r_pulse_code", 32'(pulses[i]), 32'h8);

        // Release stops pulses.
        send(8'hF0);
        send(8'h2D);
        check("held_after_break", 32'(keys_held), 32'h0);
        pulses.delete();
        idle(12);
        check("no_pulse_released", 32'(pulses.size()), 32'd0);

        // Both players: alternate starting with left.
        do_reset();
        send(8'h2D);
        send(8'h33);
        pulses.delete();
        idle(16);
        check("alt_count", 32'(pulses.size()), 32'd4);
        if (pulses.size() >= 4) begin
            check("alt_0", 32'(pulses[0]), 32'h8);
            check("alt_1", 32'(pulses[1]), 32'h1);
            check("alt_2", 32'(pulses[2]), 32'h8);
            check("alt_3", 32'(pulses[3]), 32'h1);
        end

        // Left conflict idles the left paddle until one key releases.
        do_reset();
        send(8'h2D);
        send(8'h2B);
        pulses.delete();
        idle(12);
        check("conflict_silent", 32'(pulses.size()), 32'd0);
        send(8'hF0);
        send(8'h2B);
        pulses.delete();
        idle(8);
        check("conflict_resume", 32'(pulses.size()), 32'd2);

        // Extended break and unknown codes leave held keys alone.
        send(8'hE0);
        send(8'hF0);
        send(8'h2D);
        check("ext_break_ignored", 32'(keys_held), 32'h8);
        send(8'h12);
        check("unknown_ignored", 32'(keys_held), 32'h8);

        // Reset after F0: the following byte is a make code.
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h35);
        check("reset_mid_seq", 32'(keys_held), 32'h2);

`ifdef PADDLE_PAUSE_KEY_EN
        do_reset();
        send(8'h2D);
        send(8'h29);
        check("pause_on", 32'(stand), 32'd1);
        pulses.delete();
        idle(8);
        check("pause_silent", 32'(pulses.size()), 32'd0);
        repeat (3) send(8'h29);
        check("pause_typematic", 32'(stand), 32'd1);
        send(8'hF0);
        send(8'h29);
        send(8'h29);
        check("pause_off", 32'(stand), 32'd0);
`endif

        // Random byte streams, with one reset midway.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if ($urandom_range(0, 9) < 4) send(byte_tab[$urandom_range(0, 9)]);
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
